// File: rtl/lrck_rate_detector.sv
// rtl/lrck_rate_detector.sv - measures the I2S word-clock rate and classifies it as 44.1k/48k family and x1/x2/x4/x8
module lrck_rate_detector #(
  parameter int CLK_HZ = 50_000_000,
  parameter int WINDOW = 8,
  parameter int LOCK_N = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             lrck,
  output logic             family,
  output logic [1:0]       rate,
  output logic             locked,
  output logic             changed,
  output logic [CNT_W-1:0] meas
);

  localparam int EW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [63:0] TOTAL = 64'(CLK_HZ) * 64'(WINDOW);
  localparam logic [63:0] FS [8] = '{64'd44100, 64'd48000, 64'd88200, 64'd96000,
                                     64'd176400, 64'd192000, 64'd352800, 64'd384000};
  localparam logic [63:0] N_SLOW = TOTAL / 64'd44100;
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(N_SLOW + N_SLOW / 64'd4);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(WINDOW - 1);
  localparam logic [3:0] LOCK_V = 4'(LOCK_N);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t           state, state_next;
  logic             sync_a, sync_b, sync_d, edge_flag;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [EW-1:0]    edges, edges_next;
  logic             win_close, timeout, cls_strobe;
  logic [63:0]      meas_w, nom, tol;
  logic [3:0]       hits;
  logic [2:0]       idx, hit_code, cand;
  logic             cls_valid;
  logic [3:0]       match_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync_a <= lrck;
      sync_b <= sync_a;
      sync_d <= sync_b;
    end
  end

  assign edge_flag = sync_b & ~sync_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      edges      <= '0;
      meas       <= '0;
      cls_strobe <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      edges      <= edges_next;
      cls_strobe <= win_close;
      if (win_close) meas <= cnt;
    end
  end

  // Windows run back to back; a closing edge takes priority over the timeout.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    edges_next = edges;
    win_close  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (edge_flag) begin
          cnt_next   = CNT_W'(1);
          edges_next = '0;
          state_next = MEAS;
        end
      end
      MEAS: begin
        cnt_next = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
        if (edge_flag) begin
          if (edges == LAST_EDGE) begin
            win_close  = 1'b1;
            cnt_next   = CNT_W'(1);
            edges_next = '0;
          end else begin
            edges_next = edges + EW'(1);
          end
        end
        if (!win_close && cnt >= TMAX) begin
          timeout    = 1'b1;
          cnt_next   = '0;
          edges_next = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A window is valid only when it falls inside exactly one nominal band.
  always_comb begin
    meas_w   = 64'(meas);
    nom      = '0;
    tol      = '0;
    idx      = '0;
    hits     = '0;
    hit_code = '0;
    for (int i = 0; i < 8; i++) begin
      nom = TOTAL / FS[i];
      tol = nom / 64'd64;
      idx = 3'(i);
      if ((meas_w + tol >= nom) && (meas_w <= nom + tol)) begin
        hits     = hits + 4'd1;
        hit_code = {idx[0], idx[2:1]};
      end
    end
    cls_valid = (hits == 4'd1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cand      <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
      family    <= 1'b0;
      rate      <= 2'b00;
      changed   <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (timeout || (cls_strobe && !cls_valid)) begin
        match_cnt <= '0;
        locked    <= 1'b0;
      end else if (cls_strobe) begin
        if (hit_code == cand) begin
          if (match_cnt < LOCK_V) match_cnt <= match_cnt + 4'd1;
          if (({1'b0, match_cnt} + 5'd1) >= {1'b0, LOCK_V}) begin
            locked          <= 1'b1;
            {family, rate}  <= cand;
            changed         <= ~locked;
          end
        end else begin
          cand      <= hit_code;
          match_cnt <= 4'd1;
          if (LOCK_V == 4'd1) begin
            locked         <= 1'b1;
            {family, rate} <= hit_code;
            changed        <= 1'b1;
          end else begin
            locked <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lrck_rate_detector.sv
// tb/tb_lrck_rate_detector.sv - randomized self-checking bench for lrck_rate_detector against a window-history model
`timescale 1ns/1ps
module tb_lrck_rate_detector;

  localparam int CLK_HZ = 50_000_000;
  localparam int WINDOW = 4;
  localparam int LOCK_N = 3;
  localparam int CNT_W  = 16;
  localparam longint TOTAL = longint'(CLK_HZ) * longint'(WINDOW);
  localparam int TMAX = int'(TOTAL / 44100 + TOTAL / 44100 / 4);

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             lrck = 1'b0;
  logic             family;
  logic [1:0]       rate;
  logic             locked;
  logic             changed;
  logic [CNT_W-1:0] meas;

  lrck_rate_detector #(
    .CLK_HZ(CLK_HZ),
    .WINDOW(WINDOW),
    .LOCK_N(LOCK_N),
    .CNT_W (CNT_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .lrck   (lrck),
    .family (family),
    .rate   (rate),
    .locked (locked),
    .changed(changed),
    .meas   (meas)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int meas;
    int lock;
    int code;
  } exp_t;

  exp_t pend[$];
  int   hist[$];
  int   held_code, lock_events, chg_seen, t0, ecount, meas_model;
  bit   active, lock_model;
  int   n_checks, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int classify(input int m);
    longint fs_tab [8];
    longint n, t, d;
    int hits, code;
    fs_tab = '{44100, 48000, 88200, 96000, 176400, 192000, 352800, 384000};
    hits = 0;
    code = -1;
    for (int i = 0; i < 8; i++) begin
      n = TOTAL / fs_tab[i];
      t = n / 64;
      d = longint'(m) - n;
      if (d < 0) d = -d;
      if (d <= t) begin
        hits++;
        code = (i % 2) * 4 + i / 2;
      end
    end
    return (hits == 1) ? code : -1;
  endfunction

  function automatic bit lock_from_hist();
    int last;
    if (hist.size() < LOCK_N) return 1'b0;
    last = hist[hist.size() - 1];
    if (last < 0) return 1'b0;
    for (int k = hist.size() - LOCK_N; k < hist.size(); k++)
      if (hist[k] != last) return 1'b0;
    return 1'b1;
  endfunction

  task automatic apply_result(input int r);
    exp_t e;
    bit now;
    hist.push_back(r);
    now = lock_from_hist();
    if (now && !lock_model) begin
      lock_events++;
      held_code = r;
    end
    lock_model = now;
    e.due  = cyc + 6;
    e.meas = meas_model;
    e.lock = int'(now);
    e.code = held_code;
    pend.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (changed) chg_seen++;
    while (pend.size() > 0 && pend[0].due <= cyc) begin
      e = pend.pop_front();
      check("win_meas", 32'(meas), e.meas);
      check("win_locked", 32'(locked), e.lock);
      check("win_code", 32'({family, rate}), e.code);
    end
  endtask

  task automatic model_rise();
    if (active && (cyc - t0) > TMAX) begin
      active = 1'b0;
      apply_result(-1);
    end
    if (!active) begin
      active = 1'b1;
      t0     = cyc;
      ecount = 0;
    end else begin
      ecount++;
      if (ecount == WINDOW) begin
        meas_model = cyc - t0;
        t0         = cyc;
        ecount     = 0;
        apply_result(classify(meas_model));
      end
    end
  endtask

  task automatic first_rise();
    tick();
    lrck = 1'b1;
    model_rise();
  endtask

  task automatic emit(input int p);
    int hi;
    hi = p / 2;
    repeat (hi) tick();
    lrck = 1'b0;
    repeat (p - hi) tick();
    lrck = 1'b1;
    model_rise();
  endtask

  task automatic hold_low();
    repeat (200) tick();
    lrck = 1'b0;
    repeat (TMAX + 100) tick();
    if (active) begin
      active = 1'b0;
      apply_result(-1);
    end
    repeat (8) tick();
  endtask

  task automatic model_clear();
    hist.delete();
    pend.delete();
    active     = 1'b0;
    lock_model = 1'b0;
    held_code  = 0;
    meas_model = 0;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("rst_async_locked", 32'(locked), 0);
    check("rst_async_code", 32'({family, rate}), 0);
    check("rst_async_meas", 32'(meas), 0);
    check("rst_async_changed", 32'(changed), 0);
    model_clear();
    repeat (5) tick();
    resetn = 1'b1;
  endtask

  initial begin
    int k, nom_p;
    longint fs_tab [8];
    fs_tab = '{44100, 48000, 88200, 96000, 176400, 192000, 352800, 384000};
    n_checks = 0;
    n_fail = 0;
    lock_events = 0;
    chg_seen = 0;
    model_clear();

    resetn = 1'b0;
    lrck = 1'b0;
    repeat (5) tick();
    check("reset_family", 32'(family), 0);
    check("reset_rate", 32'(rate), 0);
    check("reset_locked", 32'(locked), 0);
    check("reset_changed", 32'(changed), 0);
    check("reset_meas", 32'(meas), 0);
    resetn = 1'b1;
    repeat (5) tick();

    // Word clock above every class: nothing locks, outputs keep reset values.
    first_rise();
    repeat (3 * WINDOW) emit(113);
    repeat (8) tick();
    check("fast_locked", 32'(locked), 0);
    check("fast_code", 32'({family, rate}), 0);
    check("fast_meas", 32'(meas), 113 * WINDOW);

    repeat (3 * WINDOW) emit(1134);
    repeat (8) tick();
    check("l44_locked", 32'(locked), 1);
    check("l44_code", 32'({family, rate}), 3'b000);
    check("l44_changed_once", 32'(chg_seen), 1);

    repeat (3 * WINDOW) emit(284);
    repeat (8) tick();
    check("l176_locked", 32'(locked), 1);
    check("l176_code", 32'({family, rate}), 3'b010);

    hold_low();
    check("stop_locked", 32'(locked), 0);
    check("stop_code_held", 32'({family, rate}), 3'b010);

    first_rise();
    repeat (3 * WINDOW) emit(520);
    repeat (8) tick();
    check("l96_locked", 32'(locked), 1);
    check("l96_code", 32'({family, rate}), 3'b101);

    for (int w = 0; w < 4; w++) begin
      repeat (WINDOW) emit((w % 2) ? 1134 : 1042);
      repeat (8) tick();
      check("alt_unlocked", 32'(locked), 0);
    end

    // Reset lands mid-window while the stream is running.
    repeat (2) emit(1042);
    repeat (100) tick();
    lrck = 1'b0;
    repeat (50) tick();
    reset_pulse();
    repeat (20) tick();
    first_rise();
    repeat (3 * WINDOW) emit(1042);
    repeat (8) tick();
    check("l48_locked", 32'(locked), 1);
    check("l48_code", 32'({family, rate}), 3'b100);
    check("l48_meas", 32'(meas), 1042 * WINDOW);

    for (int r = 0; r < 2; r++) begin
      k = int'($urandom_range(4, 7));
      nom_p = int'(TOTAL / fs_tab[k] / WINDOW);
      repeat (3 * WINDOW) emit(nom_p + int'($urandom_range(0, 6)) - 3);
      repeat (8) tick();
    end

    check("changed_pulses", 32'(chg_seen), lock_events);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
